// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch front-end with one outstanding imem request and a fetch FIFO for decode.
// An address-error fetch is queued with no bus cycle, and a branch flush discards the in-flight response.
module ifetch_unit #(
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_address_i,
   input  logic        alignment_error_i,
   input  logic        flush_i,
   output logic        pc_stall_o,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_addr_ok_i,
   input  logic        imem_data_ok_i,
   input  logic [31:0] imem_rdata_i,
   output logic        if_valid_o,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_inst_o,
   output logic        if_adel_o,
   input  logic        id_ready_i
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_e;
   state_e state_q, state_d;
   logic [31:0] addr_q;
   logic [31:0] pc_m [FIFO_DEPTH];
   logic [31:0] inst_m [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] adel_m;
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, wbase, aidx;
   logic [CW-1:0] count_q, count_d, used;
   logic slot, accept, adel_push, resp_push, pop;
   assign imem_addr_o = pc_address_i;
   assign if_valid_o = count_q != '0;
   assign if_pc_o = if_valid_o ? pc_m[rd_q] : '0;
   assign if_inst_o = if_valid_o ? inst_m[rd_q] : '0;
   assign if_adel_o = if_valid_o && adel_m[rd_q];
   // The outstanding request reserves a FIFO slot for its response; the same-cycle pop is not credited.
   always_comb begin
      used = (flush_i ? '0 : count_q) + CW'(state_q != IDLE);
      slot = (state_q == IDLE || imem_data_ok_i) && used < CW'(FIFO_DEPTH);
      imem_req_o = !rst && slot && !alignment_error_i;
      accept = imem_req_o && imem_addr_ok_i;
      adel_push = !rst && slot && alignment_error_i;
      pc_stall_o = !(accept || adel_push);
      resp_push = state_q == WAIT && imem_data_ok_i && !flush_i;
      pop = if_valid_o && id_ready_i && !flush_i;
      wbase = flush_i ? '0 : wr_q;
      aidx = wbase + AW'(resp_push);
      wr_d = aidx + AW'(adel_push);
      rd_d = flush_i ? '0 : rd_q + AW'(pop);
      count_d = (flush_i ? '0 : count_q - CW'(pop)) + CW'(resp_push) + CW'(adel_push);
      state_d = (state_q == IDLE || imem_data_ok_i) ? (accept ? WAIT : IDLE)
              : (flush_i || state_q == DISCARD) ? DISCARD : WAIT;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q <= '0;
         wr_q <= '0;
         rd_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q <= accept ? pc_address_i : addr_q;
         wr_q <= wr_d;
         rd_q <= rd_d;
         count_q <= count_d;
      end
   end
   // A response and an address-error entry can land together; the response is older and goes first.
   always_ff @(posedge clk) begin
      if (resp_push) begin
         pc_m[wbase] <= addr_q;
         inst_m[wbase] <= imem_rdata_i;
         adel_m[wbase] <= 1'b0;
      end
      if (adel_push) begin
         pc_m[aidx] <= pc_address_i;
         inst_m[aidx] <= '0;
         adel_m[aidx] <= 1'b1;
      end
   end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed corner sequences plus a table-driven fetch stream checked through an expected-entry queue.
module tb_ifetch_unit;
   logic clk, rst;
   logic [31:0] pc_address_i, imem_addr_o, imem_rdata_i, if_pc_o, if_inst_o;
   logic alignment_error_i, flush_i, pc_stall_o, imem_req_o, imem_addr_ok_i, imem_data_ok_i;
   logic if_valid_o, if_adel_o, id_ready_i;
   int checks = 0, failures = 0;
   typedef struct {
      logic [31:0] addr;
      logic        err;
      logic [31:0] rdata;
      logic [31:0] exp_inst;
      logic        exp_adel;
   } vec_t;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adel;
   } ent_t;
   localparam int N = 8;
   vec_t vecs [N];
   ent_t sb [$];
   ifetch_unit #(.FIFO_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .pc_address_i(pc_address_i), .alignment_error_i(alignment_error_i),
      .flush_i(flush_i), .pc_stall_o(pc_stall_o), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_addr_ok_i(imem_addr_ok_i), .imem_data_ok_i(imem_data_ok_i), .imem_rdata_i(imem_rdata_i),
      .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o), .if_adel_o(if_adel_o),
      .id_ready_i(id_ready_i)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      pc_address_i = '0;
      alignment_error_i = 1'b0;
      flush_i = 1'b0;
      imem_addr_ok_i = 1'b0;
      imem_data_ok_i = 1'b0;
      imem_rdata_i = '0;
      id_ready_i = 1'b0;
      sb.delete();
      tick();
      rst = 1'b0;
   endtask
   task automatic run_stream(input int mode);
      int idx = 0, done = 0, cyc = 0;
      logic pend = 1'b0, pend_n;
      logic [31:0] pdata = '0, pdata_n, a;
      ent_t e;
      do_reset();
      imem_addr_ok_i = 1'b1;
      while (done < N && cyc < 300) begin
         a = idx < N ? vecs[idx].addr : 32'h4000 + 32'(cyc) * 4;
         pc_address_i = a;
         alignment_error_i = idx < N ? vecs[idx].err : 1'b0;
         imem_data_ok_i = pend;
         imem_rdata_i = pend ? pdata : '0;
         id_ready_i = mode == 0 ? 1'b1 : (cyc % 3 != 0);
         @(negedge clk);
         pend_n = 1'b0;
         pdata_n = '0;
         if (!pc_stall_o) begin
            sb.push_back('{a, idx < N ? vecs[idx].exp_inst : ~a, idx < N ? vecs[idx].exp_adel : 1'b0});
            if (!alignment_error_i) begin
               pend_n = 1'b1;
               pdata_n = idx < N ? vecs[idx].rdata : ~a;
            end
            if (idx < N) idx++;
         end
         if (if_valid_o && id_ready_i) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL stream_unexpected_entry actual_pc=%h expected=none", if_pc_o);
            end else begin
               e = sb.pop_front();
               chk("stream_pc", if_pc_o, e.pc);
               chk("stream_inst", if_inst_o, e.inst);
               chk("stream_adel", 32'(if_adel_o), 32'(e.adel));
            end
            done++;
         end
         pend = pend_n;
         pdata = pdata_n;
         tick();
         cyc++;
      end
      chk("stream_drained", 32'(done), N);
   endtask
   initial begin
      vecs[0] = '{32'h0000_0000, 1'b0, 32'h2402_0001, 32'h2402_0001, 1'b0};
      vecs[1] = '{32'h0000_0004, 1'b0, 32'h2403_0002, 32'h2403_0002, 1'b0};
      vecs[2] = '{32'h0000_0102, 1'b1, 32'h0,         32'h0,         1'b1};
      vecs[3] = '{32'h0000_0008, 1'b0, 32'h0043_0820, 32'h0043_0820, 1'b0};
      vecs[4] = '{32'h0000_000C, 1'b0, 32'hAC22_0000, 32'hAC22_0000, 1'b0};
      vecs[5] = '{32'h0000_1001, 1'b1, 32'h0,         32'h0,         1'b1};
      vecs[6] = '{32'h0000_1003, 1'b1, 32'h0,         32'h0,         1'b1};
      vecs[7] = '{32'h0000_0010, 1'b0, 32'h1000_FFFF, 32'h1000_FFFF, 1'b0};
      do_reset();
      rst = 1'b1;
      #1;
      chk("rst_stall", 32'(pc_stall_o), 1);
      chk("rst_req", 32'(imem_req_o), 0);
      chk("rst_valid", 32'(if_valid_o), 0);
      chk("rst_pc", if_pc_o, 0);
      chk("rst_inst", if_inst_o, 0);
      chk("rst_adel", 32'(if_adel_o), 0);
      // basic fetch
      do_reset();
      pc_address_i = 32'h0;
      imem_addr_ok_i = 1'b1;
      id_ready_i = 1'b1;
      #1;
      chk("basic_req", 32'(imem_req_o), 1);
      chk("basic_stall", 32'(pc_stall_o), 0);
      chk("basic_addr", imem_addr_o, 32'h0);
      tick();
      pc_address_i = 32'h4;
      imem_addr_ok_i = 1'b0;
      imem_data_ok_i = 1'b1;
      imem_rdata_i = 32'h2402_0001;
      #1;
      chk("basic_not_yet_valid", 32'(if_valid_o), 0);
      tick();
      imem_data_ok_i = 1'b0;
      #1;
      chk("basic_valid", 32'(if_valid_o), 1);
      chk("basic_pc", if_pc_o, 32'h0);
      chk("basic_inst", if_inst_o, 32'h2402_0001);
      // decode back-pressure
      do_reset();
      imem_addr_ok_i = 1'b1;
      pc_address_i = 32'h0;
      tick();
      pc_address_i = 32'h4;
      imem_data_ok_i = 1'b1;
      imem_rdata_i = 32'hA000_0000;
      tick();
      pc_address_i = 32'h8;
      imem_rdata_i = 32'hA000_0004;
      #1;
      chk("bp_full_stall", 32'(pc_stall_o), 1);
      chk("bp_full_req", 32'(imem_req_o), 0);
      tick();
      imem_data_ok_i = 1'b0;
      #1;
      chk("bp_hold_stall", 32'(pc_stall_o), 1);
      chk("bp_hold_req", 32'(imem_req_o), 0);
      tick();
      id_ready_i = 1'b1;
      #1;
      chk("bp_head0_pc", if_pc_o, 32'h0);
      chk("bp_head0_inst", if_inst_o, 32'hA000_0000);
      chk("bp_drain_stall", 32'(pc_stall_o), 1);
      tick();
      #1;
      chk("bp_head1_pc", if_pc_o, 32'h4);
      chk("bp_head1_inst", if_inst_o, 32'hA000_0004);
      chk("bp_resume_req", 32'(imem_req_o), 1);
      chk("bp_resume_addr", imem_addr_o, 32'h8);
      chk("bp_resume_stall", 32'(pc_stall_o), 0);
      // misaligned
      do_reset();
      pc_address_i = 32'h102;
      alignment_error_i = 1'b1;
      imem_addr_ok_i = 1'b1;
      #1;
      chk("adel_req", 32'(imem_req_o), 0);
      chk("adel_stall", 32'(pc_stall_o), 0);
      tick();
      #1;
      chk("adel_valid", 32'(if_valid_o), 1);
      chk("adel_flag", 32'(if_adel_o), 1);
      chk("adel_pc", if_pc_o, 32'h102);
      chk("adel_inst", if_inst_o, 32'h0);
      // flush with a response in flight
      do_reset();
      pc_address_i = 32'hE;
      alignment_error_i = 1'b1;
      tick();
      pc_address_i = 32'h10;
      alignment_error_i = 1'b0;
      imem_addr_ok_i = 1'b1;
      #1;
      chk("flush_pre_accept", 32'(pc_stall_o), 0);
      tick();
      pc_address_i = 32'h14;
      #1;
      chk("flush_wait_stall", 32'(pc_stall_o), 1);
      chk("flush_pre_valid", 32'(if_valid_o), 1);
      tick();
      flush_i = 1'b1;
      pc_address_i = 32'h80;
      #1;
      chk("flush_cycle_stall", 32'(pc_stall_o), 1);
      tick();
      flush_i = 1'b0;
      imem_data_ok_i = 1'b1;
      imem_rdata_i = 32'h0000_0BAD;
      #1;
      chk("flush_emptied", 32'(if_valid_o), 0);
      chk("flush_target_req", 32'(imem_req_o), 1);
      chk("flush_target_addr", imem_addr_o, 32'h80);
      chk("flush_target_stall", 32'(pc_stall_o), 0);
      tick();
      imem_addr_ok_i = 1'b0;
      imem_rdata_i = 32'h0080_CAFE;
      #1;
      chk("flush_dropped", 32'(if_valid_o), 0);
      tick();
      imem_data_ok_i = 1'b0;
      #1;
      chk("flush_next_valid", 32'(if_valid_o), 1);
      chk("flush_next_pc", if_pc_o, 32'h80);
      chk("flush_next_inst", if_inst_o, 32'h0080_CAFE);
      // slow memory
      do_reset();
      pc_address_i = 32'h40;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("slow_req", 32'(imem_req_o), 1);
         chk("slow_addr", imem_addr_o, 32'h40);
         chk("slow_stall", 32'(pc_stall_o), 1);
         tick();
      end
      imem_addr_ok_i = 1'b1;
      #1;
      chk("slow_accept", 32'(pc_stall_o), 0);
      tick();
      // async reset while waiting, with a late response afterwards
      do_reset();
      imem_addr_ok_i = 1'b1;
      pc_address_i = 32'h0;
      tick();
      pc_address_i = 32'h4;
      imem_data_ok_i = 1'b1;
      imem_rdata_i = 32'h1111_1111;
      tick();
      imem_data_ok_i = 1'b0;
      imem_addr_ok_i = 1'b0;
      #2;
      chk("arst_pre_valid", 32'(if_valid_o), 1);
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(if_valid_o), 0);
      chk("arst_stall", 32'(pc_stall_o), 1);
      chk("arst_req", 32'(imem_req_o), 0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      imem_data_ok_i = 1'b1;
      imem_rdata_i = 32'h2222_2222;
      tick();
      imem_data_ok_i = 1'b0;
      #1;
      chk("arst_late_data", 32'(if_valid_o), 0);
      run_stream(0);
      run_stream(1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch front-end on the consumer side of the program counter. Takes the fetch address and alignment flag from the PC, runs the instruction-memory request/response handshake, and buffers fetched instructions in a small FIFO for decode. Drives the PC stall input and discards in-flight fetches on a taken branch. Sits between the PC, instruction memory and the decode stage.

Parameters:
FIFO_DEPTH, 2, number of fetched-instruction buffer entries; power of two, at least 2.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
pc_address_i  input  32  current fetch address from PC (already branch-muxed)
alignment_error_i  input  1  pc_address_i[1:0] != 0
flush_i  input  1  branch taken this cycle; same signal as the PC's is_branch_taken
pc_stall_o  output  1  to PC stall_i; 1 = address not consumed this cycle, PC must hold
imem_req_o  output  1  fetch request valid
imem_addr_o  output  32  fetch address; equals pc_address_i
imem_addr_ok_i  input  1  memory accepted request this cycle
imem_data_ok_i  input  1  read data valid this cycle
imem_rdata_i  input  32  instruction word
if_valid_o  output  1  FIFO head valid
if_pc_o  output  32  head address
if_inst_o  output  32  head instruction
if_adel_o  output  1  head is an address-error entry
id_ready_i  input  1  decode accepts head this cycle

Behaviour:
- Async reset: state IDLE, FIFO empty, if_valid_o=0, if_pc_o=0, if_inst_o=0, if_adel_o=0. pc_stall_o=1 and imem_req_o=0 while rst is high.
- At most one memory request is outstanding. The FSM tracks it:
  - IDLE: nothing outstanding.
  - WAIT: request accepted, data is kept.
  - DISCARD: request accepted, data will be dropped.
- outstanding = (state != IDLE). space = FIFO_DEPTH - count - outstanding, using the registered count.
- Issue slot open = (state==IDLE, or state==WAIT/DISCARD with imem_data_ok_i this cycle) AND space > 0.
- When the slot is open:
  - alignment_error_i=0: imem_req_o=1. If imem_addr_ok_i=1, go to WAIT and record the address.
  - alignment_error_i=1: imem_req_o=0. Push {pc, inst=0, adel=1} directly, with no bus transaction. This counts as consumed.
- pc_stall_o = NOT (address consumed this cycle), where consumed means an accepted request or an adel push.
- Response handling:
  - imem_data_ok_i in WAIT: push {recorded pc, imem_rdata_i, adel=0}. Next state is WAIT if a new request is accepted this cycle, else IDLE.
  - imem_data_ok_i in DISCARD: data dropped. Same next-state rule.
  - imem_data_ok_i in IDLE: ignored.
- Latency: memory returns data at cycle N → if_valid_o=1 at N+1 when the FIFO was empty.
- FIFO: push and pop occur on the same edge. A pop happens when if_valid_o && id_ready_i. A simultaneous push and pop leaves count unchanged. Never push when full; the space rule guarantees this. Pointers wrap modulo FIFO_DEPTH.
- flush_i=1:
  - FIFO is cleared on that edge, and the same-cycle pop is ignored.
  - An outstanding request without data_ok this cycle moves to DISCARD.
  - A response arriving that cycle is dropped.
  - pc_address_i (the branch target) is issued that cycle if the slot is open. Space is computed as if the FIFO were empty.
- flush_i while in DISCARD: stay in DISCARD.
- Reset mid-transaction: state returns to IDLE, and any later data_ok is ignored as an IDLE response.

Test Plan:
- Basic fetch: reset, then PC=0x0, memory addr_ok immediate and data_ok one cycle later with 0x24020001 → req at cycle 1, pc_stall_o=0. if_valid_o=1 with if_pc_o=0x0 and if_inst_o=0x24020001 two cycles later.
- Decode back-pressure: id_ready_i=0, sequential fetches 0x0, 0x4 → after 2 entries pc_stall_o stays 1 with imem_req_o=0. Raising id_ready_i drains 0x0 then 0x4 in order, and fetch of 0x8 resumes.
- Misaligned: pc_address_i=0x102, alignment_error_i=1 → imem_req_o=0 and an entry with if_adel_o=1, if_pc_o=0x102, if_inst_o=0.
- Flush in flight: fetch 0x10 accepted, data delayed 3 cycles, flush_i=1 with target 0x80 → FIFO empties, 0x10 data never appears. The 0x80 request is issued in the cycle data_ok for 0x10 arrives, and 0x80 is the next if_valid_o entry.
- Slow memory: addr_ok held low for 4 cycles → imem_req_o held high with constant imem_addr_o and pc_stall_o=1 throughout. Acceptance happens on the 5th cycle.
- Async reset asserted while in WAIT, and data_ok arrives after release → no FIFO entry. if_valid_o=0 immediately on rst assertion, with no clock edge needed.
